// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer/occupancy controller for an external storage array.
// Any DEPTH >= 2; sticky overflow/underflow flags; synchronous clear.
module fifo_ptr_ctrl #(
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  output logic             wr_en_o,
  output logic             rd_en_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             full, empty;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // A pop frees a slot in the same cycle, so push-while-full is legal then.
  assign rd_en_o = pop_i & ~empty & ~clear_i;
  assign wr_en_o = push_i & ~clear_i & (~full | rd_en_o);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (push_i & ~wr_en_o & ~clear_i);
    udf_d    = udf_q | (pop_i & ~rd_en_o & ~clear_i);
    if (wr_en_o) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (rd_en_o) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    unique case ({wr_en_o, rd_en_o})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign wr_ptr_o       = wr_ptr_q;
  assign rd_ptr_o       = rd_ptr_q;
  assign count_o        = count_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (32'(count_q) >= AF_LEVEL);
  assign almost_empty_o = (32'(count_q) <= AE_LEVEL);
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Bench for fifo_ptr_ctrl: DEPTH=4 and DEPTH=5 instances on shared
// stimulus, checked against an occupancy/index model.
module tb_fifo_ptr_ctrl;

  logic clk = 1'b0;
  logic reset, clear, push, pop;
  always #5 clk = ~clk;

  logic       wr0, rd0, f0, e0, af0, ae0, ov0, un0;
  logic [1:0] wp0, rp0;
  logic [2:0] cnt0;
  logic       wr1, rd1, f1, e1, af1, ae1, ov1, un1;
  logic [2:0] wp1, rp1, cnt1;

  fifo_ptr_ctrl #(.DEPTH(4)) dut4 (
    .clk_i(clk), .reset_i(reset), .clear_i(clear),
    .push_i(push), .pop_i(pop),
    .wr_en_o(wr0), .rd_en_o(rd0),
    .wr_ptr_o(wp0), .rd_ptr_o(rp0), .count_o(cnt0),
    .full_o(f0), .empty_o(e0),
    .almost_full_o(af0), .almost_empty_o(ae0),
    .overflow_o(ov0), .underflow_o(un0)
  );

  fifo_ptr_ctrl #(.DEPTH(5)) dut5 (
    .clk_i(clk), .reset_i(reset), .clear_i(clear),
    .push_i(push), .pop_i(pop),
    .wr_en_o(wr1), .rd_en_o(rd1),
    .wr_ptr_o(wp1), .rd_ptr_o(rp1), .count_o(cnt1),
    .full_o(f1), .empty_o(e1),
    .almost_full_o(af1), .almost_empty_o(ae1),
    .overflow_o(ov1), .underflow_o(un1)
  );

  logic [31:0] o_cnt [2];
  logic [31:0] o_wp  [2];
  logic [31:0] o_rp  [2];
  logic [5:0]  o_flg [2];
  assign o_cnt[0] = 32'(cnt0);
  assign o_cnt[1] = 32'(cnt1);
  assign o_wp[0]  = 32'(wp0);
  assign o_wp[1]  = 32'(wp1);
  assign o_rp[0]  = 32'(rp0);
  assign o_rp[1]  = 32'(rp1);
  assign o_flg[0] = {f0, e0, af0, ae0, ov0, un0};
  assign o_flg[1] = {f1, e1, af1, ae1, ov1, un1};

  int total = 0;
  int bad = 0;

  // Model: occupancy plus write/read indices modulo depth.
  int dep [2] = '{4, 5};
  int m_cnt [2];
  int m_wp [2];
  int m_rp [2];
  bit m_ov [2];
  bit m_un [2];
  bit exp_wr [2];
  bit exp_rd [2];
  logic obs_wr [2];
  logic obs_rd [2];

  function automatic bit [5:0] exp_flags(int k);
    return {m_cnt[k] == dep[k], m_cnt[k] == 0,
            m_cnt[k] >= dep[k] - 1, m_cnt[k] <= 1,
            m_ov[k], m_un[k]};
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_wp[k] = 0; m_rp[k] = 0;
      m_ov[k] = 0; m_un[k] = 0;
    end
  endfunction

  // Apply inputs for one cycle; capture enables mid-cycle, state after edge.
  task automatic drive(input bit p, input bit q, input bit c);
    push = p; pop = q; clear = c;
    @(negedge clk);
    obs_wr[0] = wr0; obs_rd[0] = rd0;
    obs_wr[1] = wr1; obs_rd[1] = rd1;
    for (int k = 0; k < 2; k++) begin
      exp_rd[k] = q && !c && m_cnt[k] > 0;
      exp_wr[k] = p && !c && (m_cnt[k] < dep[k] || exp_rd[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        m_cnt[k] = 0; m_wp[k] = 0; m_rp[k] = 0;
        m_ov[k] = 0; m_un[k] = 0;
      end else begin
        if (exp_wr[k]) m_wp[k] = (m_wp[k] + 1) % dep[k];
        if (exp_rd[k]) m_rp[k] = (m_rp[k] + 1) % dep[k];
        m_cnt[k] += int'(exp_wr[k]) - int'(exp_rd[k]);
        if (p && !exp_wr[k]) m_ov[k] = 1;
        if (q && !exp_rd[k]) m_un[k] = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    push = 0; pop = 0; clear = 0; reset = 0;
    #2 reset = 1;
    #1;
    total++;
    if ({cnt0, wp0, rp0} !== 7'd0) begin
      bad++;
      $display("FAIL reset_state got cnt=%0d wp=%0d rp=%0d want 0",
               cnt0, wp0, rp0);
    end
    total++;
    if ({f0, e0, af0, ae0, ov0, un0} !== 6'b010100) begin
      bad++;
      $display("FAIL reset_flags got %b want 010100",
               {f0, e0, af0, ae0, ov0, un0});
    end
    model_reset();
    @(negedge clk) reset = 0;
    @(posedge clk) #1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 0);
      total++;
      if (obs_wr[0] !== 1'b1) begin
        bad++; $display("FAIL fill_wr_en[%0d] got %b want 1", i, obs_wr[0]);
      end
      total++;
      if (cnt0 !== 3'(i) || wp0 !== 2'(i % 4)) begin
        bad++;
        $display("FAIL fill_cnt_ptr[%0d] got cnt=%0d wp=%0d want %0d/%0d",
                 i, cnt0, wp0, i, i % 4);
      end
      total++;
      if ({af0, f0, e0} !== {i >= 3, i == 4, 1'b0}) begin
        bad++;
        $display("FAIL fill_flags[%0d] got af/f/e=%b%b%b want %b%b0",
                 i, af0, f0, e0, i >= 3, i == 4);
      end
    end
  endtask

  task automatic test_overflow();
    drive(1, 0, 0);
    total++;
    if (obs_wr[0] !== 1'b0 || ov0 !== 1'b1 || cnt0 !== 3'd4) begin
      bad++;
      $display("FAIL overflow got wr=%b ov=%b cnt=%0d want 0/1/4",
               obs_wr[0], ov0, cnt0);
    end
    drive(1, 1, 0);
    total++;
    if (obs_wr[0] !== 1'b1 || obs_rd[0] !== 1'b1) begin
      bad++;
      $display("FAIL full_pushpop_en got wr=%b rd=%b want 1/1",
               obs_wr[0], obs_rd[0]);
    end
    total++;
    if (cnt0 !== 3'd4 || wp0 !== 2'd1 || rp0 !== 2'd1) begin
      bad++;
      $display("FAIL full_pushpop got cnt=%0d wp=%0d rp=%0d want 4/1/1",
               cnt0, wp0, rp0);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 0);
      total++;
      if (cnt0 !== 3'(4 - i) || rp0 !== 2'((1 + i) % 4)) begin
        bad++;
        $display("FAIL drain[%0d] got cnt=%0d rp=%0d want %0d/%0d",
                 i, cnt0, rp0, 4 - i, (1 + i) % 4);
      end
    end
    drive(0, 1, 0);
    total++;
    if (obs_rd[0] !== 1'b0 || un0 !== 1'b1 || e0 !== 1'b1) begin
      bad++;
      $display("FAIL underflow got rd=%b un=%b e=%b want 0/1/1",
               obs_rd[0], un0, e0);
    end
    drive(0, 0, 0);
    total++;
    if (un0 !== 1'b1) begin
      bad++; $display("FAIL underflow_sticky got %b want 1", un0);
    end
    drive(1, 1, 0);
    total++;
    if (obs_rd[0] !== 1'b0 || obs_wr[0] !== 1'b1 || cnt0 !== 3'd1) begin
      bad++;
      $display("FAIL empty_pushpop got rd=%b wr=%b cnt=%0d want 0/1/1",
               obs_rd[0], obs_wr[0], cnt0);
    end
  endtask

  task automatic test_clear();
    drive(1, 0, 0);
    drive(1, 0, 0);
    total++;
    if (cnt0 !== 3'd3 || ov0 !== 1'b1) begin
      bad++;
      $display("FAIL pre_clear got cnt=%0d ov=%b want 3/1", cnt0, ov0);
    end
    drive(1, 0, 1);
    total++;
    if (obs_wr[0] !== 1'b0 || obs_rd[0] !== 1'b0) begin
      bad++;
      $display("FAIL clear_en got wr=%b rd=%b want 0/0",
               obs_wr[0], obs_rd[0]);
    end
    total++;
    if ({cnt0, wp0, rp0, ov0, un0} !== 9'd0) begin
      bad++;
      $display("FAIL clear_state got cnt=%0d wp=%0d rp=%0d ov=%b un=%b want 0",
               cnt0, wp0, rp0, ov0, un0);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0);
    drive(1, 0, 0);
    #2 reset = 1;
    #1;
    total++;
    if (cnt0 !== 3'd0 || e0 !== 1'b1 || cnt1 !== 3'd0) begin
      bad++;
      $display("FAIL async_reset got cnt=%0d e=%b want 0/1", cnt0, e0);
    end
    model_reset();
    push = 1; pop = 1;
    @(posedge clk);
    @(posedge clk) #1;
    total++;
    if (cnt0 !== 3'd0 || wp0 !== 2'd0 || cnt1 !== 3'd0) begin
      bad++;
      $display("FAIL reset_hold got cnt=%0d wp=%0d want 0/0", cnt0, wp0);
    end
    @(negedge clk);
    push = 0; pop = 0; reset = 0;
    @(posedge clk) #1;
  endtask

  task automatic test_depth5();
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 0);
      total++;
      if (wp1 !== 3'(i % 5) || f1 !== (i == 5) || cnt1 !== 3'(i)) begin
        bad++;
        $display("FAIL d5_fill[%0d] got wp=%0d f=%b cnt=%0d want %0d/%b/%0d",
                 i, wp1, f1, cnt1, i % 5, i == 5, i);
      end
    end
    for (int j = 1; j <= 7; j++) begin
      drive(1, 1, 0);
      total++;
      if (obs_wr[1] !== 1'b1 || obs_rd[1] !== 1'b1 || cnt1 !== 3'd5 ||
          rp1 !== 3'(j % 5) || wp1 !== 3'(j % 5)) begin
        bad++;
        $display("FAIL d5_pushpop[%0d] got en=%b%b cnt=%0d rp=%0d wp=%0d want 11/5/%0d/%0d",
                 j, obs_wr[1], obs_rd[1], cnt1, rp1, wp1, j % 5, j % 5);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 24) == 0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs_wr[k] !== exp_wr[k] || obs_rd[k] !== exp_rd[k]) begin
          bad++;
          $display("FAIL rnd_en[%0d] dut%0d got %b%b want %b%b",
                   n, k, obs_wr[k], obs_rd[k], exp_wr[k], exp_rd[k]);
        end
        total++;
        if (o_cnt[k] !== m_cnt[k] || o_wp[k] !== m_wp[k] ||
            o_rp[k] !== m_rp[k]) begin
          bad++;
          $display("FAIL rnd_state[%0d] dut%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                   n, k, o_cnt[k], o_wp[k], o_rp[k],
                   m_cnt[k], m_wp[k], m_rp[k]);
        end
        total++;
        if (o_flg[k] !== exp_flags(k)) begin
          bad++;
          $display("FAIL rnd_flags[%0d] dut%0d got %b want %b",
                   n, k, o_flg[k], exp_flags(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_clear();
    test_async_reset();
    test_depth5();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
